// File: rtl/complete_arb.sv
// complete_arb
//   Completion arbiter: collects results from NUM_FU functional-unit channels
//   into one holding entry per channel and broadcasts up to NUM_CDB of them per
//   cycle on the common data bus, round-robin from rr_ptr.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   flush                    drop every held result and any pending broadcast
//   fu_valid/fu_ready        per-channel completion handshake
//   fu_result/preg/rob       flattened per-channel payload, channel i at [i*W +: W]
//   cdb_valid/data/preg/rob  registered broadcast slots, valid for one cycle
//   preg_ready_set           registered one-hot OR of broadcast tags (tag 0 excluded)
//   stall_cnt                saturating count of cycles with an ungranted held entry

// One holding entry per channel. The load strobe is already qualified by
// fu_ready, so it never fires in a flush or reset cycle.
module complete_arb_lane #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              grant,
  input  logic [XLEN-1:0]   din,
  input  logic [PREG_W-1:0] pin,
  input  logic [ROB_W-1:0]  rin,
  output logic              hold_v,
  output logic [XLEN-1:0]   data,
  output logic [PREG_W-1:0] preg,
  output logic [ROB_W-1:0]  rob
);
  always_ff @(posedge clk) begin
    if (rst)        hold_v <= 1'b0;
    else if (flush) hold_v <= 1'b0;
    else if (load)  hold_v <= 1'b1;   // reload wins over a same-edge grant
    else if (grant) hold_v <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data <= din;
      preg <= pin;
      rob  <= rin;
    end
  end
endmodule

module complete_arb #(
  parameter int NUM_FU  = 4,
  parameter int NUM_CDB = 2,
  parameter int XLEN    = 32,
  parameter int PREG_W  = 6,
  parameter int ROB_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_FU-1:0]         fu_valid,
  output logic [NUM_FU-1:0]         fu_ready,
  input  logic [NUM_FU*XLEN-1:0]    fu_result,
  input  logic [NUM_FU*PREG_W-1:0]  fu_preg,
  input  logic [NUM_FU*ROB_W-1:0]   fu_rob,
  output logic [NUM_CDB-1:0]        cdb_valid,
  output logic [NUM_CDB*XLEN-1:0]   cdb_data,
  output logic [NUM_CDB*PREG_W-1:0] cdb_preg,
  output logic [NUM_CDB*ROB_W-1:0]  cdb_rob,
  output logic [2**PREG_W-1:0]      preg_ready_set,
  output logic [15:0]               stall_cnt
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int PW1   = PTR_W + 1;
  localparam int CNT_W = $clog2(NUM_CDB + 1);
  localparam logic [PW1-1:0]   FU_W    = PW1'(NUM_FU);
  localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(NUM_FU - 1);
  localparam logic [CNT_W-1:0] CDB_MAX = CNT_W'(NUM_CDB);

  // unpacked views of the flattened payload buses (same bit layout)
  logic [NUM_FU-1:0][XLEN-1:0]   in_data;
  logic [NUM_FU-1:0][PREG_W-1:0] in_preg;
  logic [NUM_FU-1:0][ROB_W-1:0]  in_rob;
  assign in_data = fu_result;
  assign in_preg = fu_preg;
  assign in_rob  = fu_rob;

  logic [NUM_FU-1:0]             hold_v;
  logic [NUM_FU-1:0][XLEN-1:0]   hold_data;
  logic [NUM_FU-1:0][PREG_W-1:0] hold_preg;
  logic [NUM_FU-1:0][ROB_W-1:0]  hold_rob;

  logic [PTR_W-1:0] rr_ptr;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] accept;

  // registered broadcast state
  logic [NUM_CDB-1:0]             cdb_v_q;
  logic [NUM_CDB-1:0][XLEN-1:0]   cdb_d_q;
  logic [NUM_CDB-1:0][PREG_W-1:0] cdb_p_q;
  logic [NUM_CDB-1:0][ROB_W-1:0]  cdb_r_q;

  // ---------------------------------------------------------------- grant
  // Walk the channels starting at rr_ptr, wrapping at NUM_FU, and hand the
  // first NUM_CDB held entries to slots 0,1,... in that order. Only registered
  // state feeds this, so fu_ready never depends on fu_valid.
  logic [NUM_CDB-1:0]            slot_v;
  logic [NUM_CDB-1:0][PTR_W-1:0] slot_idx;
  logic [PTR_W-1:0]              last_idx;
  logic                          any_grant;
  logic [CNT_W-1:0]              cnt;
  logic [PW1-1:0]                sum;
  logic [PTR_W-1:0]              idx;

  always_comb begin
    grant     = '0;
    slot_v    = '0;
    slot_idx  = '0;
    last_idx  = '0;
    any_grant = 1'b0;
    cnt       = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr} + PW1'(k);
      if (sum >= FU_W) sum = sum - FU_W;
      idx = sum[PTR_W-1:0];
      if (hold_v[idx] && (cnt < CDB_MAX)) begin
        grant[idx] = 1'b1;
        for (int s = 0; s < NUM_CDB; s++) begin
          if (cnt == CNT_W'(s)) begin
            slot_v[s]   = 1'b1;
            slot_idx[s] = idx;
          end
        end
        cnt       = cnt + CNT_W'(1);
        last_idx  = idx;
        any_grant = 1'b1;
      end
    end
  end

  // a channel may refill the same edge its held entry leaves on the bus
  assign fu_ready = {NUM_FU{!rst && !flush}} & (~hold_v | grant);
  assign accept   = fu_valid & fu_ready;

  // ---------------------------------------------------------------- lanes
  for (genvar g = 0; g < NUM_FU; g++) begin : g_lane
    complete_arb_lane #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .load   (accept[g]),
      .grant  (grant[g]),
      .din    (in_data[g]),
      .pin    (in_preg[g]),
      .rin    (in_rob[g]),
      .hold_v (hold_v[g]),
      .data   (hold_data[g]),
      .preg   (hold_preg[g]),
      .rob    (hold_rob[g])
    );
  end

  // ---------------------------------------------------------------- next bus
  logic [NUM_CDB-1:0][XLEN-1:0]   nxt_data;
  logic [NUM_CDB-1:0][PREG_W-1:0] nxt_preg;
  logic [NUM_CDB-1:0][ROB_W-1:0]  nxt_rob;
  logic [2**PREG_W-1:0]           nxt_mask;

  // Tag 0 is the architectural zero register: it still broadcasts but never
  // marks anything ready. Duplicate tags simply OR into the same bit.
  always_comb begin
    nxt_data = '0;
    nxt_preg = '0;
    nxt_rob  = '0;
    nxt_mask = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      nxt_data[s] = hold_data[slot_idx[s]];
      nxt_preg[s] = hold_preg[slot_idx[s]];
      nxt_rob[s]  = hold_rob[slot_idx[s]];
      if (slot_v[s] && (nxt_preg[s] != '0)) nxt_mask[nxt_preg[s]] = 1'b1;
    end
  end

  logic [PTR_W-1:0] rr_nxt;
  logic             stall_now;
  assign rr_nxt    = (last_idx == LAST_FU) ? '0 : last_idx + PTR_W'(1);
  assign stall_now = |(hold_v & ~grant);

  // ---------------------------------------------------------------- registers
  // Flush suppresses this cycle's broadcast but leaves rr_ptr and stall_cnt
  // as they were; the discarded grants never happened as far as fairness goes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_v_q        <= '0;
      cdb_d_q        <= '0;
      cdb_p_q        <= '0;
      cdb_r_q        <= '0;
      preg_ready_set <= '0;
      rr_ptr         <= '0;
      stall_cnt      <= '0;
    end else if (flush) begin
      cdb_v_q        <= '0;
      preg_ready_set <= '0;
    end else begin
      cdb_v_q        <= slot_v;
      cdb_d_q        <= nxt_data;
      cdb_p_q        <= nxt_preg;
      cdb_r_q        <= nxt_rob;
      preg_ready_set <= nxt_mask;
      if (any_grant) rr_ptr <= rr_nxt;
      if (stall_now && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign cdb_valid = cdb_v_q;
  assign cdb_data  = cdb_d_q;
  assign cdb_preg  = cdb_p_q;
  assign cdb_rob   = cdb_r_q;
endmodule

// File: tb/tb_complete_arb.sv
// tb_complete_arb
//   Directed scenarios for the completion arbiter plus a randomized run
//   checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_complete_arb;
  localparam int NF = 4;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [3:0]    fu_valid, fu_ready;
  logic [127:0]  fu_result;
  logic [23:0]   fu_preg;
  logic [15:0]   fu_rob;
  logic [1:0]    cdb_valid;
  logic [63:0]   cdb_data;
  logic [11:0]   cdb_preg;
  logic [7:0]    cdb_rob;
  logic [63:0]   preg_ready_set;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int failures = 0;

  complete_arb #(.NUM_FU(NF), .NUM_CDB(NC), .XLEN(32), .PREG_W(6), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_result(fu_result), .fu_preg(fu_preg), .fu_rob(fu_rob),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_preg(cdb_preg), .cdb_rob(cdb_rob),
    .preg_ready_set(preg_ready_set), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [31:0] d, input logic [5:0] p, input logic [3:0] r);
    fu_valid[i] = 1'b1;
    fu_result[i*32 +: 32] = d;
    fu_preg[i*6 +: 6] = p;
    fu_rob[i*4 +: 4] = r;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; fu_valid = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ------------------------------------------------------------ model
  bit          m_hv[4];
  logic [31:0] m_d[4];
  logic [5:0]  m_p[4];
  logic [3:0]  m_r[4];
  bit          m_gr[4];
  int          m_g[$];
  int          m_rr, m_stall;
  logic [1:0]  m_cv;
  logic [31:0] m_cd[2];
  logic [5:0]  m_cp[2];
  logic [3:0]  m_cr[2];
  logic [63:0] m_mask;

  function automatic void model_clear();
    for (int i = 0; i < NF; i++) m_hv[i] = 1'b0;
    m_rr = 0; m_stall = 0; m_cv = '0; m_mask = '0;
  endfunction

  // up to NC held channels, visited in order rr, rr+1, ... mod NF
  function automatic void calc_grants();
    m_g.delete();
    for (int i = 0; i < NF; i++) m_gr[i] = 1'b0;
    for (int k = 0; k < NF; k++) begin
      int i = (m_rr + k) % NF;
      if (m_hv[i] && m_g.size() < NC) begin
        m_g.push_back(i);
        m_gr[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    calc_grants();
    for (int i = 0; i < NF; i++) r[i] = !rst && !flush && (!m_hv[i] || m_gr[i]);
    return r;
  endfunction

  function automatic void model_edge();
    logic [3:0] rdy;
    bit left;
    rdy = exp_ready();
    if (rst) begin
      model_clear();
    end else if (flush) begin
      for (int i = 0; i < NF; i++) m_hv[i] = 1'b0;
      m_cv = '0; m_mask = '0;
    end else begin
      m_cv = '0; m_mask = '0; left = 1'b0;
      for (int s = 0; s < m_g.size(); s++) begin
        m_cv[s] = 1'b1;
        m_cd[s] = m_d[m_g[s]];
        m_cp[s] = m_p[m_g[s]];
        m_cr[s] = m_r[m_g[s]];
        if (m_cp[s] != 0) m_mask = m_mask | (64'd1 << m_cp[s]);
      end
      if (m_g.size() > 0) m_rr = (m_g[m_g.size()-1] + 1) % NF;
      for (int i = 0; i < NF; i++) if (m_hv[i] && !m_gr[i]) left = 1'b1;
      if (left && m_stall < 65535) m_stall++;
      for (int i = 0; i < NF; i++) begin
        if (m_gr[i]) m_hv[i] = 1'b0;
        if (fu_valid[i] && rdy[i]) begin
          m_hv[i] = 1'b1;
          m_d[i] = fu_result[i*32 +: 32];
          m_p[i] = fu_preg[i*6 +: 6];
          m_r[i] = fu_rob[i*4 +: 4];
        end
      end
    end
  endfunction

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fu_valid = '0;
    fu_result = '0; fu_preg = '0; fu_rob = '0;
    tick(); tick();
    checks++; if (cdb_valid !== 2'b00) begin failures++; $display("FAIL reset_cdb_valid got=%b exp=00", cdb_valid); end
    checks++; if (preg_ready_set !== 64'd0) begin failures++; $display("FAIL reset_mask got=%h exp=0", preg_ready_set); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    checks++; if (cdb_data !== 64'd0) begin failures++; $display("FAIL reset_cdb_data got=%h exp=0", cdb_data); end
    checks++; if (fu_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", fu_ready); end
    rst = 1'b0; #1;
    checks++; if (fu_ready !== 4'b1111) begin failures++; $display("FAIL post_reset_ready got=%b exp=1111", fu_ready); end
  endtask

  task automatic test_single();
    do_reset();
    set_ch(0, 32'hDEADBEEF, 6'd5, 4'd3);
    tick();
    fu_valid = '0;
    checks++; if (cdb_valid !== 2'b00) begin failures++; $display("FAIL single_early got=%b exp=00", cdb_valid); end
    tick();
    checks++; if (cdb_valid !== 2'b01) begin failures++; $display("FAIL single_valid got=%b exp=01", cdb_valid); end
    checks++; if (cdb_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", cdb_data[31:0]); end
    checks++; if (cdb_preg[5:0] !== 6'd5) begin failures++; $display("FAIL single_preg got=%0d exp=5", cdb_preg[5:0]); end
    checks++; if (cdb_rob[3:0] !== 4'd3) begin failures++; $display("FAIL single_rob got=%0d exp=3", cdb_rob[3:0]); end
    checks++; if (preg_ready_set !== 64'h20) begin failures++; $display("FAIL single_mask got=%h exp=20", preg_ready_set); end
    tick();
    checks++; if (cdb_valid !== 2'b00) begin failures++; $display("FAIL single_oneshot got=%b exp=00", cdb_valid); end
    checks++; if (preg_ready_set !== 64'd0) begin failures++; $display("FAIL single_mask_clear got=%h exp=0", preg_ready_set); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < NF; i++) set_ch(i, 32'hA000_0000 + i, 6'(10 + i), 4'(i));
    tick();
    fu_valid = '0; #1;
    checks++; if (fu_ready !== 4'b0011) begin failures++; $display("FAIL cont_ready got=%b exp=0011", fu_ready); end
    tick();
    checks++; if (cdb_valid !== 2'b11) begin failures++; $display("FAIL cont_v1 got=%b exp=11", cdb_valid); end
    checks++; if (cdb_data !== {32'hA000_0001, 32'hA000_0000}) begin failures++; $display("FAIL cont_d1 got=%h exp=a0000001a0000000", cdb_data); end
    checks++; if (preg_ready_set !== ((64'd1 << 10) | (64'd1 << 11))) begin failures++; $display("FAIL cont_m1 got=%h", preg_ready_set); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL cont_stall1 got=%0d exp=1", stall_cnt); end
    tick();
    checks++; if (cdb_valid !== 2'b11) begin failures++; $display("FAIL cont_v2 got=%b exp=11", cdb_valid); end
    checks++; if (cdb_data !== {32'hA000_0003, 32'hA000_0002}) begin failures++; $display("FAIL cont_d2 got=%h exp=a0000003a0000002", cdb_data); end
    checks++; if (cdb_rob !== {4'd3, 4'd2}) begin failures++; $display("FAIL cont_rob2 got=%h exp=32", cdb_rob); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL cont_stall2 got=%0d exp=1", stall_cnt); end
    tick();
    checks++; if (cdb_valid !== 2'b00) begin failures++; $display("FAIL cont_idle got=%b exp=00", cdb_valid); end
    // rr_ptr is back at 0 when channels 0 and 1 win again
    for (int i = 0; i < NF; i++) set_ch(i, 32'hB000_0000 + i, 6'(20 + i), 4'(i));
    tick();
    fu_valid = '0;
    tick();
    checks++; if (cdb_data !== {32'hB000_0001, 32'hB000_0000}) begin failures++; $display("FAIL cont_rr got=%h exp=b0000001b0000000", cdb_data); end
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL cont_stall3 got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      set_ch(1, 32'h1000 + n, 6'(30 + n), 4'(n));
      #1;
      checks++; if (fu_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready n=%0d got=%b exp=1", n, fu_ready[1]); end
      tick();
      if (n >= 1) begin
        checks++; if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'h1000 + n - 1)
          begin failures++; $display("FAIL b2b_cdb n=%0d got=%b/%h exp=01/%h", n, cdb_valid, cdb_data[31:0], 32'h1000 + n - 1); end
      end
    end
    fu_valid = '0;
    tick();
    checks++; if (cdb_valid !== 2'b01 || cdb_data[31:0] !== 32'h1005) begin failures++; $display("FAIL b2b_last got=%b/%h exp=01/1005", cdb_valid, cdb_data[31:0]); end
  endtask

  task automatic test_flush();
    do_reset();
    set_ch(0, 32'hF0, 6'd3, 4'd1);
    set_ch(2, 32'hF2, 6'd4, 4'd2);
    tick();
    fu_valid = '0;
    flush = 1'b1;
    set_ch(3, 32'hF3, 6'd6, 4'd6);
    #1;
    checks++; if (fu_ready !== 4'b0000) begin failures++; $display("FAIL flush_ready got=%b exp=0000", fu_ready); end
    tick();
    flush = 1'b0; fu_valid = '0;
    checks++; if (cdb_valid !== 2'b00) begin failures++; $display("FAIL flush_cdb got=%b exp=00", cdb_valid); end
    checks++; if (preg_ready_set !== 64'd0) begin failures++; $display("FAIL flush_mask got=%h exp=0", preg_ready_set); end
    tick();
    checks++; if (cdb_valid !== 2'b00) begin failures++; $display("FAIL flush_drop got=%b exp=00", cdb_valid); end
    set_ch(1, 32'hF1, 6'd9, 4'd4);
    tick();
    fu_valid = '0;
    tick();
    checks++; if (cdb_valid !== 2'b01 || cdb_preg[5:0] !== 6'd9) begin failures++; $display("FAIL flush_after got=%b/%0d exp=01/9", cdb_valid, cdb_preg[5:0]); end
  endtask

  task automatic test_tags();
    do_reset();
    set_ch(0, 32'h77, 6'd0, 4'd0);
    tick();
    fu_valid = '0;
    tick();
    checks++; if (cdb_valid !== 2'b01) begin failures++; $display("FAIL tag0_valid got=%b exp=01", cdb_valid); end
    checks++; if (preg_ready_set !== 64'd0) begin failures++; $display("FAIL tag0_mask got=%h exp=0", preg_ready_set); end
    set_ch(1, 32'h71, 6'd7, 4'd1);
    set_ch(2, 32'h72, 6'd7, 4'd2);
    tick();
    fu_valid = '0;
    tick();
    checks++; if (cdb_valid !== 2'b11) begin failures++; $display("FAIL dup_valid got=%b exp=11", cdb_valid); end
    checks++; if (cdb_preg !== {6'd7, 6'd7}) begin failures++; $display("FAIL dup_preg got=%h exp=1c7", cdb_preg); end
    checks++; if (preg_ready_set !== 64'h80) begin failures++; $display("FAIL dup_mask got=%h exp=80", preg_ready_set); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < NF; i++) set_ch(i, 32'hC0 + i, 6'(40 + i), 4'(i));
    tick();
    fu_valid = '0;
    tick();
    rst = 1'b1; flush = 1'b1; #1;
    checks++; if (fu_ready !== 4'b0000) begin failures++; $display("FAIL rmid_ready got=%b exp=0000", fu_ready); end
    tick();
    rst = 1'b0; flush = 1'b0;
    checks++; if (cdb_valid !== 2'b00) begin failures++; $display("FAIL rmid_cdb got=%b exp=00", cdb_valid); end
    checks++; if ({cdb_data, cdb_preg, cdb_rob} !== '0) begin failures++; $display("FAIL rmid_fields got=%h/%h/%h exp=0", cdb_data, cdb_preg, cdb_rob); end
    checks++; if (preg_ready_set !== 64'd0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL rmid_mask_stall got=%h/%0d exp=0/0", preg_ready_set, stall_cnt); end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (cdb_valid !== 2'b00) begin failures++; $display("FAIL rmid_never n=%0d got=%b exp=00", n, cdb_valid); end
    end
  endtask

  task automatic test_random();
    logic [3:0] er;
    do_reset();
    model_clear();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      fu_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NF; i++) begin
        fu_result[i*32 +: 32] = $urandom;
        fu_preg[i*6 +: 6] = 6'($urandom_range(0, 7));
        fu_rob[i*4 +: 4] = 4'($urandom_range(0, 15));
      end
      #2;
      er = exp_ready();
      checks++; if (fu_ready !== er) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, fu_ready, er); end
      checks++; if (cdb_valid !== m_cv) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, cdb_valid, m_cv); end
      for (int s = 0; s < NC; s++) begin
        if (m_cv[s]) begin
          checks++;
          if (cdb_data[s*32 +: 32] !== m_cd[s] || cdb_preg[s*6 +: 6] !== m_cp[s] || cdb_rob[s*4 +: 4] !== m_cr[s]) begin
            failures++;
            $display("FAIL rnd_slot c=%0d s=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", c, s,
                     cdb_data[s*32 +: 32], cdb_preg[s*6 +: 6], cdb_rob[s*4 +: 4], m_cd[s], m_cp[s], m_cr[s]);
          end
        end
      end
      checks++; if (preg_ready_set !== m_mask) begin failures++; $display("FAIL rnd_mask c=%0d got=%h exp=%h", c, preg_ready_set, m_mask); end
      checks++; if (stall_cnt !== 16'(m_stall)) begin failures++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); end
      @(posedge clk);
      model_edge();
      #1;
    end
    rst = 1'b0; flush = 1'b0; fu_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_tags();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/complete_arb.md
COMPLETE_ARB -- requirements
Module: complete_arb

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, meaning number of functional-unit completion channels.
REQ-002 SHALL have parameter NUM_CDB, default 2, meaning broadcast slots per cycle; 1 <= NUM_CDB <= NUM_FU.
REQ-003 SHALL have parameter XLEN, default 32, meaning result width.
REQ-004 SHALL have parameter PREG_W, default 6, meaning physical-register tag width.
REQ-005 SHALL have parameter ROB_W, default 4, meaning ROB index width.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1, meaning the synchronous active-high reset.
REQ-009 SHALL have port flush, input, 1, meaning discard all held and pending results.
REQ-010 SHALL have port fu_valid, input, NUM_FU, meaning one completion request per channel.
REQ-011 SHALL have port fu_ready, output, NUM_FU, meaning the channel accepts this cycle.
REQ-012 SHALL have port fu_result, input, NUM_FU*XLEN, meaning results, channel i at bits [i*XLEN +: XLEN].
REQ-013 SHALL have port fu_preg, input, NUM_FU*PREG_W, meaning destination physical tags.
REQ-014 SHALL have port fu_rob, input, NUM_FU*ROB_W, meaning ROB row indices.
REQ-015 SHALL have ports cdb_valid, cdb_data, cdb_preg and cdb_rob, all outputs, widths NUM_CDB, NUM_CDB*XLEN, NUM_CDB*PREG_W and NUM_CDB*ROB_W, meaning the registered broadcast slots.
REQ-016 SHALL have port preg_ready_set, output, 2**PREG_W, meaning a registered mask of tags that become ready this cycle.
REQ-017 SHALL have port stall_cnt, output, 16, meaning a saturating count of contention cycles.

Function
REQ-018 SHALL hold one result per channel: hold_v, data, preg and rob.
REQ-019 SHALL accept channel i on a rising edge when fu_valid[i] and fu_ready[i] are both 1; the holding entry then loads and hold_v sets.
REQ-020 SHALL drive fu_ready[i] = !flush && (!hold_v[i] || grant[i]); grant SHALL depend only on registered state, with no fu_valid to fu_ready path.
REQ-021 SHALL grant up to NUM_CDB held entries per cycle, scanning from rr_ptr upward modulo NUM_FU.
REQ-022 SHALL assign granted entries to cdb slots 0, 1, ... in scan order; unused slots SHALL have cdb_valid 0, and their data, preg and rob fields SHALL be don't-care.
REQ-023 SHALL register granted entries onto the cdb outputs at the next edge; they SHALL be valid for exactly one cycle.
REQ-024 SHALL give a minimum latency of 1 cycle: a result accepted at edge E, granted in the following cycle, appears on cdb after edge E+1.
REQ-025 SHALL clear hold_v[i] on the grant edge, unless a new request on channel i is accepted on the same edge, in which case the entry reloads.
REQ-026 SHALL advance rr_ptr to (last granted index + 1) mod NUM_FU; with no grant, rr_ptr SHALL be unchanged.
REQ-027 SHALL set preg_ready_set with the OR of one-hot(cdb_preg[k]) over all valid slots, registered together with the cdb outputs; tag 0 SHALL never set a bit but SHALL still broadcast.
REQ-028 SHALL broadcast both slots when two valid slots carry the same tag; the mask bit SHALL be set once.
REQ-029 SHALL increment stall_cnt when at least one held entry is left ungranted in a cycle, saturating at 16'hFFFF.
REQ-030 SHALL on flush clear all hold_v and all cdb_valid, and zero preg_ready_set, at that edge; no new acceptance SHALL occur in that cycle; rr_ptr and stall_cnt SHALL be kept.
REQ-031 SHALL make flush take priority over grant: entries granted in a flush cycle are not broadcast.

Reset
REQ-032 SHALL on rst clear hold_v, cdb_valid, preg_ready_set, rr_ptr and stall_cnt to 0 at the edge; cdb_data, cdb_preg and cdb_rob SHALL reset to 0.
REQ-033 SHALL drive fu_ready to 0 while rst is high; rst SHALL override flush and any in-flight transfer.

Verification
REQ-034 SHALL cover single completion: ch0 valid with result 32'hDEADBEEF, preg 5, rob 3 -> one cycle later cdb slot0 valid with the same fields, preg_ready_set bit 5 high for one cycle.
REQ-035 SHALL cover contention: all 4 channels valid at once with NUM_CDB 2 and rr_ptr 0 -> ch0 and ch1 broadcast, then ch2 and ch3, rr_ptr ends at 0, stall_cnt = 1.
REQ-036 SHALL cover back-to-back traffic: ch1 valid every cycle, uncontended -> one broadcast per cycle and fu_ready[1] held at 1.
REQ-037 SHALL cover flush: two channels held and flush pulsed -> no broadcast next cycle, fu_ready 0 during the flush cycle, and a later request still completes.
REQ-038 SHALL cover tag 0 and duplicate tags: preg 0 sets no mask bit but cdb_valid = 1; two slots with preg 7 -> both valid and mask bit 7 only.
REQ-039 SHALL cover reset mid-operation: rst asserted with entries held -> all outputs 0 next cycle, and held results are never broadcast.
